// File: rtl/axi4_lite_regfile_slave_pkg.sv
// Shared definitions for the AXI4-lite register-file slave.
//   resp_t     : AXI response encoding used on BRESP/RRESP.
//   ADDR_LSB   : byte-address bits below the 32-bit word index.
//   DEFAULT_ID : default contents of the read-only register 0.
//   to_index() : byte address -> word index. The result keeps every upper
//                address bit, so callers can range-check the full address
//                and slice off the low bits for the array index.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  localparam int          ADDR_LSB   = 2;
  localparam logic [31:0] DEFAULT_ID = 32'hA11C_0001;

  function automatic logic [63:0] to_index(input logic [63:0] addr);
    return addr >> ADDR_LSB;
  endfunction

endpackage

// File: rtl/axi4_lite_regfile_slave_if.sv
// AXI4-lite signal bundle (AW/W/B/AR/R channels).
//   master modport : drives addresses, data, valids and B/R readies.
//   slave modport  : drives A/W readies, responses and B/R valids.
interface axi4_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import axi4_lite_pkg::*;

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axi4_lite_regfile_slave_wr_ctrl.sv
// Write-side controller: one-entry hold buffers for AW and W, commit
// decision, and the B channel.
//   clk, rst          : clock, synchronous active-high reset.
//   awaddr/awvalid/awready, wdata/wvalid/wready : write address/data channels.
//   bresp/bvalid/bready : write response channel.
//   reg_we/reg_idx/reg_wdata : register write strobe into the top-level array.
// A commit fires when both buffers are full and no response is outstanding;
// both buffers drain in that same cycle so the readies rise the next cycle.
module axi4_lite_regfile_wr_ctrl
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_WIDTH-1:0]       awaddr,
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic                        wvalid,
  output logic                        wready,
  output logic [1:0]                  bresp,
  output logic                        bvalid,
  input  logic                        bready,
  output logic                        reg_we,
  output logic [$clog2(NUM_REGS)-1:0] reg_idx,
  output logic [DATA_WIDTH-1:0]       reg_wdata
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic                  aw_full;
  logic                  w_full;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic                  bvalid_q;
  resp_t                 bresp_q;

  logic [63:0]           word_idx;
  logic                  in_range;
  logic                  wr_ok;
  logic                  commit;

  // Decode of the buffered address; register 0 is read-only, so writes to it
  // are rejected just like out-of-range addresses.
  always_comb begin
    word_idx = to_index(64'(aw_addr_q));
    in_range = (word_idx < 64'(NUM_REGS));
    wr_ok    = in_range && (word_idx != 64'd0);
    commit   = aw_full && w_full && !bvalid_q;
  end

  assign awready   = !aw_full;
  assign wready    = !w_full;
  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign reg_we    = commit && wr_ok;
  assign reg_idx   = word_idx[IDX_W-1:0];
  assign reg_wdata = w_data_q;

  // Buffer flags and B channel. Commit only happens with both flags set, so
  // a handshake can never coincide with the drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
    end else begin
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end else begin
        if (awvalid && !aw_full) aw_full <= 1'b1;
        if (wvalid && !w_full)   w_full  <= 1'b1;
      end

      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? OKAY : SLVERR;
      end else if (bvalid_q && bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Buffer payloads: qualified by the full flags, so they need no reset.
  always_ff @(posedge clk) begin
    if (awvalid && !aw_full) aw_addr_q <= awaddr;
    if (wvalid && !w_full)   w_data_q  <= wdata;
  end

endmodule

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-lite slave implementing a bank of NUM_REGS 32-bit registers.
//   ACLK, ARESET : clock, synchronous active-high reset.
//   bus          : AXI4-lite slave port (AW/W/B/AR/R).
//   regs_o       : flat view of all registers, register i at [i*32 +: 32].
// Register 0 always reads ID_VALUE and ignores writes. Reads have a
// one-cycle registered latency and run independently of the write path.
module axi4_lite_regfile_slave
  import axi4_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DEFAULT_ID
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axi4_lite_if.slave                     bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  reg_we;
  logic [IDX_W-1:0]      reg_idx;
  logic [DATA_WIDTH-1:0] reg_wdata;

  logic [63:0]           ar_word;
  logic [IDX_W-1:0]      ar_idx;
  logic                  ar_in_range;
  logic                  ar_hs;

  logic                  rd_vld_p1;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  resp_t                 rd_resp_p1;

  axi4_lite_regfile_wr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_wr_ctrl (
    .clk       (ACLK),
    .rst       (ARESET),
    .awaddr    (bus.AWADDR),
    .awvalid   (bus.AWVALID),
    .awready   (bus.AWREADY),
    .wdata     (bus.WDATA),
    .wvalid    (bus.WVALID),
    .wready    (bus.WREADY),
    .bresp     (bus.BRESP),
    .bvalid    (bus.BVALID),
    .bready    (bus.BREADY),
    .reg_we    (reg_we),
    .reg_idx   (reg_idx),
    .reg_wdata (reg_wdata)
  );

  // Register array. Entry 0 is loaded with the ID on reset and the write
  // controller never strobes it, so it stays constant.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == 0) ? ID_VALUE : '0;
      end
    end else if (reg_we) begin
      regs[reg_idx] <= reg_wdata;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  always_comb begin
    ar_word     = to_index(64'(bus.ARADDR));
    ar_idx      = ar_word[IDX_W-1:0];
    ar_in_range = (ar_word < 64'(NUM_REGS));
    ar_hs       = bus.ARVALID && !rd_vld_p1;
  end

  // ---- read stage p1: registered R channel ----
  // The array is sampled before any same-edge commit lands, so a read that
  // coincides with a write to the same register returns the old value.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_vld_p1  <= 1'b0;
      rd_data_p1 <= '0;
      rd_resp_p1 <= OKAY;
    end else if (ar_hs) begin
      rd_vld_p1  <= 1'b1;
      rd_data_p1 <= ar_in_range ? regs[ar_idx] : '0;
      rd_resp_p1 <= ar_in_range ? OKAY : SLVERR;
    end else if (rd_vld_p1 && bus.RREADY) begin
      rd_vld_p1 <= 1'b0;
    end
  end

  assign bus.ARREADY = !rd_vld_p1;
  assign bus.RVALID  = rd_vld_p1;
  assign bus.RDATA   = rd_data_p1;
  assign bus.RRESP   = rd_resp_p1;

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Directed bench for axi4_lite_regfile_slave (NUM_REGS=16): a vector table
// of write/read pairs with hand-computed responses, followed by hand-written
// sequences for buffering, back-pressure, read/write collision and reset.
module tb_axi4_lite_regfile_slave;

  localparam logic [31:0] ID = 32'hA11C_0001;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [511:0] regs_o;

  int total = 0;
  int bad   = 0;

  axi4_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_regfile_slave dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus),
    .regs_o (regs_o)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [1:0]  bresp;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t        vt [6];
  logic [31:0] mdl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_of(input int i);
    return regs_o[i*32 +: 32];
  endfunction

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  // Coincident AW+W from an idle slave with BREADY=1; lat counts edges from
  // the handshake edge (1) up to the edge where BVALID appears, -1 on timeout.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          output logic [1:0] resp, output int lat);
    bus.AWADDR  = a;
    bus.WDATA   = d;
    bus.AWVALID = 1'b1;
    bus.WVALID  = 1'b1;
    resp        = 2'b11;
    tick;
    lat         = 1;
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    while (!bus.BVALID && lat < 10) begin
      tick;
      lat++;
    end
    if (bus.BVALID) resp = bus.BRESP;
    else            lat  = -1;
    tick;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                         output logic [1:0] resp, output logic vld);
    bus.ARADDR  = a;
    bus.ARVALID = 1'b1;
    tick;
    bus.ARVALID = 1'b0;
    vld  = bus.RVALID;
    data = bus.RDATA;
    resp = bus.RRESP;
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        rvld;
    int          lat;
    logic [31:0] wa;

    vt[0] = '{32'h0000_0004, 32'hDEAD_BEEF, 2'b00, 32'h0000_0004, 32'hDEAD_BEEF, 2'b00};
    vt[1] = '{32'h0000_0040, 32'h1111_1111, 2'b10, 32'h0000_0040, 32'h0000_0000, 2'b10};
    vt[2] = '{32'h0000_0000, 32'h2222_2222, 2'b10, 32'h0000_0000, ID,            2'b00};
    vt[3] = '{32'h0000_003C, 32'hCAFE_F00D, 2'b00, 32'h0000_003C, 32'hCAFE_F00D, 2'b00};
    vt[4] = '{32'h0000_0007, 32'h0BAD_F00D, 2'b00, 32'h0000_0004, 32'h0BAD_F00D, 2'b00};
    vt[5] = '{32'h1000_0004, 32'h9999_9999, 2'b10, 32'h1000_0004, 32'h0000_0000, 2'b10};

    for (int i = 0; i < 16; i++) mdl[i] = (i == 0) ? ID : 32'h0;

    ARESET      = 1'b1;
    bus.AWADDR  = '0;
    bus.AWVALID = 1'b0;
    bus.WDATA   = '0;
    bus.WVALID  = 1'b0;
    bus.BREADY  = 1'b1;
    bus.ARADDR  = '0;
    bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b1;
    tick;
    tick;
    ARESET = 1'b0;

    // ---- reset state ----
    chk("rst awready", 32'(bus.AWREADY), 32'd1);
    chk("rst wready",  32'(bus.WREADY),  32'd1);
    chk("rst arready", 32'(bus.ARREADY), 32'd1);
    chk("rst bvalid",  32'(bus.BVALID),  32'd0);
    chk("rst rvalid",  32'(bus.RVALID),  32'd0);
    chk("rst bresp",   32'(bus.BRESP),   32'd0);
    chk("rst rresp",   32'(bus.RRESP),   32'd0);
    chk("rst rdata",   bus.RDATA,        32'd0);
    chk("rst reg0",    reg_of(0),        ID);
    chk("rst reg1",    reg_of(1),        32'd0);

    // ---- vector table ----
    for (int i = 0; i < 6; i++) begin
      do_write(vt[i].waddr, vt[i].wdata, resp, lat);
      chk($sformatf("v%0d b-latency", i), 32'(lat), 32'd2);
      chk($sformatf("v%0d bresp", i), 32'(resp), 32'(vt[i].bresp));
      if (vt[i].bresp == 2'b00) begin
        wa = vt[i].waddr;
        mdl[wa[5:2]] = vt[i].wdata;
      end
      do_read(vt[i].raddr, rdata, resp, rvld);
      chk($sformatf("v%0d rvalid", i), 32'(rvld), 32'd1);
      chk($sformatf("v%0d rdata", i), rdata, vt[i].rdata);
      chk($sformatf("v%0d rresp", i), 32'(resp), 32'(vt[i].rresp));
      for (int r = 0; r < 16; r++) begin
        chk($sformatf("v%0d regs_o[%0d]", i, r), reg_of(r), mdl[r]);
      end
    end

    // ---- W three cycles ahead of AW ----
    bus.WDATA  = 32'h1234_5678;
    bus.WVALID = 1'b1;
    tick;
    bus.WVALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("early-w wready %0d", k), 32'(bus.WREADY), 32'd0);
      chk($sformatf("early-w awready %0d", k), 32'(bus.AWREADY), 32'd1);
      chk($sformatf("early-w bvalid %0d", k), 32'(bus.BVALID), 32'd0);
      if (k < 2) tick;
    end
    bus.AWADDR  = 32'h0000_0008;
    bus.AWVALID = 1'b1;
    tick;
    bus.AWVALID = 1'b0;
    chk("early-w commit awready", 32'(bus.AWREADY), 32'd0);
    chk("early-w commit bvalid", 32'(bus.BVALID), 32'd0);
    tick;
    chk("early-w bvalid", 32'(bus.BVALID), 32'd1);
    chk("early-w bresp", 32'(bus.BRESP), 32'd0);
    chk("early-w wready back", 32'(bus.WREADY), 32'd1);
    chk("early-w awready back", 32'(bus.AWREADY), 32'd1);
    chk("early-w reg2", reg_of(2), 32'h1234_5678);
    tick;
    chk("early-w bvalid clear", 32'(bus.BVALID), 32'd0);
    tick;
    chk("early-w single b", 32'(bus.BVALID), 32'd0);

    // ---- BREADY held low, second write buffered ----
    bus.BREADY  = 1'b0;
    bus.AWADDR  = 32'h0000_0010;
    bus.WDATA   = 32'hA5A5_A5A5;
    bus.AWVALID = 1'b1;
    bus.WVALID  = 1'b1;
    tick;
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    tick;
    chk("bp first bvalid", 32'(bus.BVALID), 32'd1);
    chk("bp reg4", reg_of(4), 32'hA5A5_A5A5);
    bus.AWADDR  = 32'h0000_0014;
    bus.WDATA   = 32'h5A5A_5A5A;
    bus.AWVALID = 1'b1;
    bus.WVALID  = 1'b1;
    tick;
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp hold bvalid %0d", k), 32'(bus.BVALID), 32'd1);
      chk($sformatf("bp hold bresp %0d", k), 32'(bus.BRESP), 32'd0);
      chk($sformatf("bp hold awready %0d", k), 32'(bus.AWREADY), 32'd0);
      chk($sformatf("bp hold wready %0d", k), 32'(bus.WREADY), 32'd0);
      chk($sformatf("bp hold reg5 %0d", k), reg_of(5), 32'd0);
      tick;
    end
    bus.BREADY = 1'b1;
    tick;
    chk("bp after hs bvalid", 32'(bus.BVALID), 32'd0);
    tick;
    chk("bp second bvalid", 32'(bus.BVALID), 32'd1);
    chk("bp reg5", reg_of(5), 32'h5A5A_5A5A);
    tick;
    chk("bp second clear", 32'(bus.BVALID), 32'd0);

    // ---- RREADY held low ----
    bus.RREADY  = 1'b0;
    bus.ARADDR  = 32'h0000_0010;
    bus.ARVALID = 1'b1;
    tick;
    bus.ARVALID = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rp hold rvalid %0d", k), 32'(bus.RVALID), 32'd1);
      chk($sformatf("rp hold rdata %0d", k), bus.RDATA, 32'hA5A5_A5A5);
      chk($sformatf("rp hold arready %0d", k), 32'(bus.ARREADY), 32'd0);
      tick;
    end
    bus.RREADY = 1'b1;
    tick;
    chk("rp rvalid clear", 32'(bus.RVALID), 32'd0);
    chk("rp arready back", 32'(bus.ARREADY), 32'd1);

    // ---- same-cycle commit and read of 0x0C ----
    do_write(32'h0000_000C, 32'h3333_3333, resp, lat);
    chk("coll pre bresp", 32'(resp), 32'd0);
    bus.AWADDR  = 32'h0000_000C;
    bus.WDATA   = 32'h4444_4444;
    bus.AWVALID = 1'b1;
    bus.WVALID  = 1'b1;
    tick;
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    bus.ARADDR  = 32'h0000_000C;
    bus.ARVALID = 1'b1;
    tick;
    bus.ARVALID = 1'b0;
    chk("coll rvalid", 32'(bus.RVALID), 32'd1);
    chk("coll old value", bus.RDATA, 32'h3333_3333);
    chk("coll bvalid", 32'(bus.BVALID), 32'd1);
    chk("coll reg3", reg_of(3), 32'h4444_4444);
    tick;
    do_read(32'h0000_000C, rdata, resp, rvld);
    chk("coll new value", rdata, 32'h4444_4444);

    // ---- reset with AW buffered and B pending ----
    bus.BREADY  = 1'b0;
    bus.AWADDR  = 32'h0000_0004;
    bus.WDATA   = 32'h0000_0055;
    bus.AWVALID = 1'b1;
    bus.WVALID  = 1'b1;
    tick;
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    tick;
    chk("mid-rst bvalid before", 32'(bus.BVALID), 32'd1);
    chk("mid-rst reg1 before", reg_of(1), 32'h0000_0055);
    bus.AWADDR  = 32'h0000_0008;
    bus.AWVALID = 1'b1;
    tick;
    bus.AWVALID = 1'b0;
    chk("mid-rst aw buffered", 32'(bus.AWREADY), 32'd0);
    ARESET = 1'b1;
    tick;
    ARESET = 1'b0;
    chk("mid-rst bvalid", 32'(bus.BVALID), 32'd0);
    chk("mid-rst awready", 32'(bus.AWREADY), 32'd1);
    chk("mid-rst wready", 32'(bus.WREADY), 32'd1);
    chk("mid-rst arready", 32'(bus.ARREADY), 32'd1);
    chk("mid-rst reg1", reg_of(1), 32'd0);
    chk("mid-rst reg2", reg_of(2), 32'd0);
    bus.BREADY = 1'b1;
    tick;
    chk("mid-rst no stray b", 32'(bus.BVALID), 32'd0);
    do_write(32'h0000_0008, 32'h0000_0077, resp, lat);
    chk("post-rst b-latency", 32'(lat), 32'd2);
    chk("post-rst reg2", reg_of(2), 32'h0000_0077);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
